// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os
// Purpose  : Oversampling UART receiver with configurable data width, parity
//            and stop bits. Two-flop input synchroniser, 3-sample majority
//            vote per bit, start-bit glitch rejection, per-frame parity and
//            framing flags, one-entry output register with valid/ready
//            handshake and overrun reporting.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous active-high reset
//            rx         - asynchronous serial line, idle high
//            data_out   - received word, LSB = first bit on the line
//            parity_err - parity mismatch on the held word
//            frame_err  - a stop bit of the held word sampled 0
//            overrun    - held word overwrote an unaccepted word
//            out_valid  - held word is valid
//            out_ready  - consumer accepts when out_valid && out_ready
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_os #(
   parameter int CLOCK_FREQ = 50000000,
   parameter int BAUD_RATE  = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int DIV_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW      = $clog2(OVERSAMPLE);
   localparam int BW      = $clog2(DATA_BITS + 1);

   localparam logic [TW-1:0] C_TICK_LAST = TW'(DIV - 1);
   localparam logic [SW-1:0] C_S0        = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] C_S1        = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] C_DEC       = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [SW-1:0] C_LAST      = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] C_NBITS     = BW'(DATA_BITS);
   localparam logic          C_STOP_LAST = 1'(STOP_BITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [1:0]           r_sync;
   logic                 r_rs_prev;
   logic [TW-1:0]        r_tick_cnt;
   logic [SW-1:0]        r_phase;
   logic [2:0]           r_state;
   logic                 r_s0;
   logic                 r_s1;
   logic [DATA_BITS-1:0] r_shift;
   logic [BW-1:0]        r_bit_cnt;
   logic                 r_stop_cnt;
   logic                 r_pe;
   logic                 r_fe;

   logic [DATA_BITS-1:0] r_data;
   logic                 r_pe_o;
   logic                 r_fe_o;
   logic                 r_ovr;
   logic                 r_valid;

   logic w_rs;
   logic w_tick;
   logic w_dec;
   logic w_end;
   logic w_vote;
   logic w_commit;

   assign w_rs   = r_sync[1];
   assign w_tick = (r_tick_cnt == C_TICK_LAST);
   assign w_dec  = (r_phase == C_DEC);
   assign w_end  = (r_phase == C_LAST);
   // Two earlier samples plus the live sample at the decision tick.
   assign w_vote = (r_s0 & r_s1) | (r_s0 & w_rs) | (r_s1 & w_rs);
   // Commit at the decision tick of the last stop bit so the next start edge
   // has half a bit of margin.
   assign w_commit = w_tick && (r_state == S_STOP) && w_dec && (r_stop_cnt == C_STOP_LAST);

   // Synchroniser and free-running tick generator
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync     <= 2'b11;
         r_tick_cnt <= '0;
      end else begin
         r_sync     <= {r_sync[0], rx};
         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      end
   end

   // Frame FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rs_prev  <= 1'b1;
         r_phase    <= '0;
         r_state    <= S_IDLE;
         r_s0       <= 1'b1;
         r_s1       <= 1'b1;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_pe       <= 1'b0;
         r_fe       <= 1'b0;
      end else begin
         r_rs_prev <= w_rs;
         if (r_state == S_IDLE) begin
            r_phase <= '0;
            // Only a fresh 1->0 edge arms a frame; a held-low line does not.
            if (r_rs_prev && !w_rs) begin
               r_state <= S_START;
               r_pe    <= 1'b0;
               r_fe    <= 1'b0;
            end
         end else if (w_tick) begin
            r_phase <= w_end ? '0 : r_phase + 1'b1;
            if (r_phase == C_S0) r_s0 <= w_rs;
            if (r_phase == C_S1) r_s1 <= w_rs;
            case (r_state)
               S_START: begin
                  if (w_dec && w_vote) begin
                     r_state <= S_IDLE;          // glitch, not a start bit
                  end else if (w_end) begin
                     r_state   <= S_DATA;
                     r_bit_cnt <= '0;
                  end
               end
               S_DATA: begin
                  if (w_dec) begin
                     r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
                  if (w_end && (r_bit_cnt == C_NBITS)) begin
                     r_state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                     r_stop_cnt <= 1'b0;
                  end
               end
               S_PARITY: begin
                  // Odd wants XOR(data, parity) = 1, even wants 0.
                  if (w_dec) r_pe <= ((^r_shift) ^ w_vote) != (PARITY == 1);
                  if (w_end) begin
                     r_state    <= S_STOP;
                     r_stop_cnt <= 1'b0;
                  end
               end
               S_STOP: begin
                  if (w_dec) begin
                     if (!w_vote) r_fe <= 1'b1;
                     if (r_stop_cnt == C_STOP_LAST) r_state <= S_IDLE;
                  end else if (w_end) begin
                     r_stop_cnt <= 1'b1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Output holding register with valid/ready handshake
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data  <= '0;
         r_pe_o  <= 1'b0;
         r_fe_o  <= 1'b0;
         r_ovr   <= 1'b0;
         r_valid <= 1'b0;
      end else if (w_commit) begin
         r_data  <= r_shift;
         r_pe_o  <= r_pe;
         r_fe_o  <= r_fe | ~w_vote;
         r_valid <= 1'b1;
         // A simultaneous accept retires the old word, so no overrun.
         r_ovr   <= r_valid & ~out_ready;
      end else if (r_valid && out_ready) begin
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end
   end

   assign data_out   = r_data;
   assign parity_err = r_pe_o;
   assign frame_err  = r_fe_o;
   assign overrun    = r_ovr;
   assign out_valid  = r_valid;

endmodule
`default_nettype wire

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised, oversampling UART receiver: the next-generation serial front end feeding the hasher's byte stream. It generalises the fixed 8N1 receiver with configurable data width, parity and stop bits. It adds a two-flop input synchroniser, 3-sample majority voting, start-bit glitch rejection and per-frame parity/framing error flags. Received words are held in a one-entry output register with a valid/ready handshake and overrun reporting.

## Interface
- CLOCK_FREQ, 50000000, system clock frequency in Hz
- BAUD_RATE, 115200, line bit rate
- OVERSAMPLE, 16, sample ticks per bit; even, ≥ 8
- DATA_BITS, 8, data bits per frame, 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- clk  in  1  single system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- rx  in  1  asynchronous serial line, idle high
- data_out  out  DATA_BITS  received word, LSB = first bit on the line
- parity_err  out  1  parity mismatch on the held word; 0 when PARITY = 0
- frame_err  out  1  a stop bit sampled 0 for the held word
- overrun  out  1  the held word overwrote an unaccepted word
- out_valid  out  1  the held word is valid
- out_ready  in  1  consumer accepts the word when out_valid && out_ready at a clk edge

## Operation
- Synchroniser: rx passes two flops; both reset to 1. All logic uses the synchronised value rs.
- Tick generator: DIV = CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE), integer-truncated. It issues a one-clk tick every DIV clocks and free-runs.
- Sample counter: counts ticks 0..OVERSAMPLE-1 within a bit; phase resets to 0 on start detect.
- Bit value: majority of rs at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. Bit decision is at tick OVERSAMPLE/2+1.
- FSM states:
  - IDLE: a falling edge on rs (previous 1, current 0) goes to START and clears the tick phase.
  - START: if the voted bit is 1, the start is a glitch; return to IDLE with no output change. If it is 0, go to DATA at the bit end (tick OVERSAMPLE-1).
  - DATA: shift voted bits LSB-first. After DATA_BITS bits, go to PARITY if PARITY ≠ 0, else STOP.
  - PARITY: compare the voted bit with the parity over the data bits (odd: XOR of data and parity bit = 1; even: = 0). Record the mismatch.
  - STOP: vote each of STOP_BITS bits. Any 0 sets the frame_err candidate. At the decision tick of the last stop bit, commit and go to IDLE immediately, not at bit end. This gives half-bit margin for the next start.
- Commit: data_out, parity_err and frame_err load from the frame; out_valid is set to 1.
  - overrun is set to 1 if out_valid = 1 and out_ready = 0 in the commit cycle, else 0.
  - The old word is overwritten.
- Accept: out_valid && out_ready with no commit that cycle. out_valid goes to 0 and overrun goes to 0; data_out and the flags hold their values.
- Commit and accept in the same cycle: the old word is accepted, the new word loads, out_valid stays 1, overrun = 0.
- Frame-error frames (including a break) are still committed. IDLE re-arms only on a fresh 1→0 edge, so a held-low line produces no repeat frames.

## Timing
- Reset values: data_out = 0, parity_err = 0, frame_err = 0, overrun = 0, out_valid = 0, FSM = IDLE, tick/sample counters = 0, synchroniser flops = 1.
- Reset mid-frame: the frame is discarded and no commit occurs.
- Input latency: 2 clk through the synchroniser.
- Commit timing: outputs change on the clk edge after the decision tick of the last stop bit, i.e. (1 + DATA_BITS + (PARITY≠0) + STOP_BITS - 1) bit times + (OVERSAMPLE/2+2) ticks after start detect, ±1 tick of phase.
- out_valid stays high until accepted; it has no timeout.
- Counters: the tick counter is sized by $clog2(DIV); the bit counter by $clog2(DATA_BITS+1). The tick counter wraps from DIV-1 to 0.

## Test plan
- 8N1, byte 0xA5 sent at 115200 with out_ready = 1 → one out_valid cycle, data_out = 0xA5, parity_err = frame_err = overrun = 0.
- PARITY = 2, byte 0x37 with parity bit 0 (correct value is 1) → data_out = 0x37, parity_err = 1, frame_err = 0. The same byte with parity bit 1 → parity_err = 0.
- 8N1, byte 0x55 with stop bit driven 0 → frame_err = 1, data_out = 0x55. A line held low afterwards produces no second out_valid.
- rx low pulse of 3·DIV clocks (< OVERSAMPLE/2 ticks), then idle → no out_valid, FSM back in IDLE; a following 0x3C frame is received correctly.
- out_ready = 0, frames 0x11 then 0x22 → data_out = 0x22, overrun = 1, out_valid = 1. out_ready pulsed 1 → out_valid = 0, overrun = 0.
- reset asserted mid-byte after the 4th data bit, released, then frame 0xC3 sent → all outputs at reset values during reset, no partial word committed, 0xC3 received cleanly.
